// File: rtl/adpll_pkg.sv
// Shared ADPLL types: phase-detector FSM states, the signed error word, saturation helper.
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } ped_state_e;

  localparam int ERROR_WIDTH_DEF = 5;

  typedef logic signed [ERROR_WIDTH_DEF-1:0] error_t;

  // Symmetric limit: the most negative code is never produced.
  function automatic int max_mag(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/phase_error_detector_if.sv
// Edge inputs and error outputs of the phase error detector; lock_o exists only with PED_LOCK_DETECT_EN.
interface phase_error_detector_if #(
  parameter int ERROR_WIDTH = 5
) ();
  logic                          ref_i;
  logic                          fb_i;
  logic signed [ERROR_WIDTH-1:0] error_o;
  logic                          error_valid_o;
`ifdef PED_LOCK_DETECT_EN
  logic                          lock_o;

  modport master (output ref_i, fb_i, input error_o, error_valid_o, lock_o);
  modport slave  (input ref_i, fb_i, output error_o, error_valid_o, lock_o);
`else
  modport master (output ref_i, fb_i, input error_o, error_valid_o);
  modport slave  (input ref_i, fb_i, output error_o, error_valid_o);
`endif
endinterface

// File: rtl/edge_sync.sv
// Synchroniser plus registered rise detector; edges are suppressed until the chain holds real samples.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic gen_clk_i,
  input  logic reset_n_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic                   prev_q;
  logic                   rise_q;

  // fill_q[SYNC_STAGES] marks prev_q as a genuine sample, so a level already high at release is no edge.
  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q & fill_q[SYNC_STAGES];
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/phase_error_detector.sv
// Phase/frequency detector: measures ref-vs-fb edge lead in gen_clk_i cycles, saturated signed output.
// Optional lock indicator enabled by defining PED_LOCK_DETECT_EN.
module phase_error_detector
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH    = 5,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
`ifdef PED_LOCK_DETECT_EN
  ,
  parameter int LOCK_THRESH    = 1,
  parameter int LOCK_COUNT     = 8
`endif
) (
  input  logic gen_clk_i,
  input  logic reset_n_i,
  phase_error_detector_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic signed [ERROR_WIDTH-1:0] MAX_S = ERROR_WIDTH'(max_mag(ERROR_WIDTH));

  logic ref_rise, fb_rise;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .gen_clk_i (gen_clk_i),
    .reset_n_i (reset_n_i),
    .async_i   (bus.ref_i),
    .rise_o    (ref_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .gen_clk_i (gen_clk_i),
    .reset_n_i (reset_n_i),
    .async_i   (bus.fb_i),
    .rise_o    (fb_rise)
  );

  ped_state_e                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic signed [ERROR_WIDTH-1:0] error_q, error_d;
  logic                          valid_q, valid_d;
  logic signed [ERROR_WIDTH-1:0] mag_s;
  logic                          timeout;

  assign timeout = (cnt_q == TIMEOUT_C);
  assign mag_s   = (32'(cnt_q) > 32'(max_mag(ERROR_WIDTH))) ? MAX_S : ERROR_WIDTH'(cnt_q);

  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      error_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      valid_q <= valid_d;
    end
  end

  // A new edge of the leading signal always restarts the count, whether or not the partner arrived too.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ref_rise && !fb_rise) begin
          state_d = REF_LEAD;
          cnt_d   = CNT_ONE;
        end else if (fb_rise && !ref_rise) begin
          state_d = FB_LEAD;
          cnt_d   = CNT_ONE;
        end
      end
      REF_LEAD: begin
        if (ref_rise) begin
          cnt_d = CNT_ONE;
        end else if (fb_rise || timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      FB_LEAD: begin
        if (fb_rise) begin
          cnt_d = CNT_ONE;
        end else if (ref_rise || timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    error_d = error_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ref_rise && fb_rise) begin
          valid_d = 1'b1;
          error_d = '0;
        end
      end
      REF_LEAD: begin
        if (fb_rise) begin
          valid_d = 1'b1;
          error_d = mag_s;
        end else if (ref_rise || timeout) begin
          valid_d = 1'b1;
          error_d = MAX_S;
        end
      end
      FB_LEAD: begin
        if (ref_rise) begin
          valid_d = 1'b1;
          error_d = -mag_s;
        end else if (fb_rise || timeout) begin
          valid_d = 1'b1;
          error_d = -MAX_S;
        end
      end
      default: ;
    endcase
  end

  assign bus.error_o       = error_q;
  assign bus.error_valid_o = valid_q;

`ifdef PED_LOCK_DETECT_EN
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT);

  logic [RUN_W-1:0]   run_q;
  logic               lock_q;
  logic signed [31:0] err_ext;
  logic               in_thresh;

  assign err_ext   = 32'(error_q);
  assign in_thresh = (err_ext <= LOCK_THRESH) && (err_ext >= -LOCK_THRESH);

  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      run_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      if (valid_q) begin
        if (!in_thresh)          run_q <= '0;
        else if (run_q != RUN_MAX) run_q <= run_q + 1'b1;
      end
      if (valid_q && !in_thresh) lock_q <= 1'b0;
      else if (run_q == RUN_MAX) lock_q <= 1'b1;
    end
  end

  assign bus.lock_o = lock_q;
`endif

endmodule

// File: tb/tb_phase_error_detector.sv
// Directed bench for phase_error_detector; lock checks run when PED_LOCK_DETECT_EN is defined.
module tb_phase_error_detector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phase_error_detector_if #(.ERROR_WIDTH(5)) bus_if ();

  phase_error_detector #(
    .ERROR_WIDTH    (5),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (64)
`ifdef PED_LOCK_DETECT_EN
    ,
    .LOCK_THRESH    (1),
    .LOCK_COUNT     (8)
`endif
  ) dut (
    .gen_clk_i (clk),
    .reset_n_i (rst_n),
    .bus       (bus_if.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobes = 0;
  int last_cyc = 0;
  int err_log[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus_if.error_valid_o === 1'b1) begin
      strobes++;
      last_cyc = cyc;
      err_log.push_back(int'(bus_if.error_o));
      $display("strobe cycle=%0d error=%0d", cyc, bus_if.error_o);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int s, c;

  initial begin
    bus_if.ref_i = 1'b0;
    bus_if.fb_i  = 1'b0;
    tick(3);
    chk("reset_error", int'(bus_if.error_o), 0);
    chk("reset_valid", int'(bus_if.error_valid_o), 0);
    rst_n = 1'b1;
    tick(5);
    chk("idle_no_strobe", strobes, 0);

    // Test 1: ref leads fb by 5
    s = strobes;
    bus_if.ref_i = 1'b1;
    tick(5);
    bus_if.fb_i = 1'b1;
    c = cyc;
    tick(8);
    bus_if.ref_i = 1'b0; bus_if.fb_i = 1'b0;
    tick(6);
    chk("t1_count", strobes - s, 1);
    chk("t1_error", err_log[s], 5);
    chk("t1_latency", last_cyc, c + 4);
    chk("t1_hold", int'(bus_if.error_o), 5);

    // Test 2: fb leads ref by 3
    s = strobes;
    bus_if.fb_i = 1'b1;
    tick(3);
    bus_if.ref_i = 1'b1;
    tick(8);
    bus_if.ref_i = 1'b0; bus_if.fb_i = 1'b0;
    tick(6);
    chk("t2_count", strobes - s, 1);
    chk("t2_error", err_log[s], -3);
    chk("t2_bits", int'(unsigned'(bus_if.error_o)), 29);

    // Test 3: simultaneous edges, then nothing more (FSM back in IDLE)
    s = strobes;
    bus_if.ref_i = 1'b1; bus_if.fb_i = 1'b1;
    c = cyc;
    tick(8);
    bus_if.ref_i = 1'b0; bus_if.fb_i = 1'b0;
    tick(6);
    chk("t3_count", strobes - s, 1);
    chk("t3_error", err_log[s], 0);
    chk("t3_latency", last_cyc, c + 4);
    tick(70);
    chk("t3_stays_idle", strobes - s, 1);

    // Test 4a: ref leads by 40, saturates
    s = strobes;
    bus_if.ref_i = 1'b1;
    tick(40);
    bus_if.fb_i = 1'b1;
    tick(8);
    bus_if.ref_i = 1'b0; bus_if.fb_i = 1'b0;
    tick(6);
    chk("t4a_count", strobes - s, 1);
    chk("t4a_error", err_log[s], 15);

    // Test 4b: ref with no fb, timeout after 64 counted cycles
    s = strobes;
    bus_if.ref_i = 1'b1;
    c = cyc;
    tick(5);
    bus_if.ref_i = 1'b0;
    tick(75);
    chk("t4b_count", strobes - s, 1);
    chk("t4b_error", err_log[s], 15);
    chk("t4b_latency", last_cyc, c + 68);

    // Test 5: cycle slip then normal measurement
    s = strobes;
    bus_if.ref_i = 1'b1;
    tick(3);
    bus_if.ref_i = 1'b0;
    tick(7);
    bus_if.ref_i = 1'b1;
    tick(4);
    bus_if.fb_i = 1'b1;
    tick(8);
    bus_if.ref_i = 1'b0; bus_if.fb_i = 1'b0;
    tick(6);
    chk("t5_count", strobes - s, 2);
    chk("t5_slip", err_log[s], 15);
    chk("t5_error", err_log[s+1], 4);
    chk("t5_hold", int'(bus_if.error_o), 4);

    // Test 6: reset mid-measurement, ref held high through release
    s = strobes;
    bus_if.ref_i = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_error", int'(bus_if.error_o), 0);
    chk("t6_rst_valid", int'(bus_if.error_valid_o), 0);
    tick(2);
    chk("t6_rst_error_held", int'(bus_if.error_o), 0);
    rst_n = 1'b1;
    tick(80);
    chk("t6_no_strobe", strobes - s, 0);
    bus_if.ref_i = 1'b0;
    tick(5);

`ifdef PED_LOCK_DETECT_EN
    chk("lock_after_reset", int'(bus_if.lock_o), 0);
    s = strobes;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("lock_before_8th", int'(bus_if.lock_o), 0);
      if (i % 2 == 0) begin
        bus_if.ref_i = 1'b1; tick(1); bus_if.fb_i = 1'b1;
      end else begin
        bus_if.fb_i = 1'b1; tick(1); bus_if.ref_i = 1'b1;
      end
      tick(6);
      bus_if.ref_i = 1'b0; bus_if.fb_i = 1'b0;
      tick(6);
    end
    chk("lock_count", strobes - s, 8);
    chk("lock_first_err", err_log[s], 1);
    chk("lock_second_err", err_log[s+1], -1);
    chk("lock_asserted", int'(bus_if.lock_o), 1);
    s = strobes;
    bus_if.ref_i = 1'b1;
    tick(3);
    bus_if.fb_i = 1'b1;
    tick(8);
    bus_if.ref_i = 1'b0; bus_if.fb_i = 1'b0;
    chk("unlock_err", err_log[s], 3);
    chk("lock_dropped", int'(bus_if.lock_o), 0);
    tick(6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
